serializer: RTL
===============

SERIALIZER -- requirements
Module: serializer

Interface
REQ-001 The block SHALL have one clock and SHALL use an asynchronous, active-high reset.
REQ-002 Port `clk_100khz`: input, 1 bit, 100 kHz system clock; all state updates on its rising edge.
REQ-003 Port `reset`: input, 1 bit, asynchronous active-high reset.
REQ-004 Port `data_in`: input, 8 bits, parallel byte to transmit.
REQ-005 Port `data_valid`: input, 1 bit, byte-push request.
REQ-006 Port `byte_ready`: output, 1 bit, FIFO can accept a byte (= not full).
REQ-007 Port `data_out`: output, 1 bit, serial bit to the receiver.
REQ-008 Port `write_out`: output, 1 bit, strobe marking `data_out` valid.
REQ-009 Port `status_in`: input, 1 bit, receiver free (driven from the deserializer `status_out`).
REQ-010 Port `tx_busy`: output, 1 bit, FSM not in IDLE.
REQ-011 Port `fifo_count`: output, 3 bits, bytes queued (0..4).
REQ-012 Port `bytes_sent`: output, 8 bits, count of completed bytes.

Function
REQ-013 The input FIFO SHALL be 4 entries × 8 bits, first-in first-out.
REQ-014 A push SHALL occur on a rising edge where `data_valid` is 1 and `byte_ready` is 1; `data_in` is captured at that edge.
REQ-015 `byte_ready` SHALL be derived only from FIFO-full. A push while full SHALL be dropped silently, even if a pop occurs in the same cycle.
REQ-016 A pop SHALL use only the count at the start of the cycle. A byte pushed at edge N SHALL be poppable no earlier than edge N+1.
REQ-017 For a simultaneous push and pop with 1 ≤ count ≤ 3, `fifo_count` SHALL be unchanged and both operations SHALL take effect.
REQ-018 The FSM SHALL have three states: IDLE, SHIFT, GAP.
REQ-019 IDLE SHALL go to SHIFT at an edge where the FIFO is non-empty and `status_in` is 1. At that edge the FSM SHALL pop the head into the shift register, set `data_out` to head[7], set `write_out` to 1, and clear the bit counter.
REQ-020 In IDLE with FIFO empty or `status_in` at 0, the FSM SHALL remain in IDLE with `write_out` at 0.
REQ-021 In SHIFT, on each edge while the bit counter is below 7, the FSM SHALL increment the counter and output the next lower bit.
- Bits SHALL be sent MSB first.
- `write_out` SHALL stay high for exactly 8 consecutive cycles per byte.
REQ-022 In SHIFT with the bit counter at 7, the next edge SHALL move the FSM to GAP, set `write_out` to 0 and `data_out` to 0, and increment `bytes_sent` modulo 256 (255 wraps to 0).
REQ-023 GAP SHALL go to IDLE unconditionally after one cycle. The minimum low time of `write_out` between bytes SHALL therefore be 2 cycles.
REQ-024 `status_in` SHALL be ignored in SHIFT and GAP; a drop mid-byte SHALL NOT abort or stall transmission.
REQ-025 `data_out` SHALL be 0 whenever `write_out` is 0.
REQ-026 All outputs SHALL be registered, except `byte_ready`, `tx_busy` and `fifo_count`, which are decoded from registers.

Reset
REQ-027 While `reset` is 1, regardless of clock, the block SHALL force:
- FSM to IDLE
- `write_out` = 0, `data_out` = 0
- FIFO emptied, `fifo_count` = 0, `byte_ready` = 1
- `tx_busy` = 0, `bytes_sent` = 0
REQ-028 Reset asserted mid-byte SHALL abort the byte immediately. The partial byte SHALL NOT be counted or resumed.
REQ-029 After reset deasserts, the first push SHALL be accepted on the next qualifying edge.

Verification
REQ-030 Push 0x55 with `status_in` = 1 -> `write_out` high for 8 cycles, starting the edge after the push edge. `data_out` = 0,1,0,1,0,1,0,1. `bytes_sent` = 1. A deserializer attached to these outputs receives `data_out` = 0x55.
REQ-031 Queue 0xA5 with `status_in` = 0 for 10 cycles -> `write_out` stays 0, `tx_busy` = 0, `fifo_count` = 1. Then set `status_in` to 1 -> transmission starts at the next edge with `data_out` = 1 (bit 7).
REQ-032 Push 5 bytes (0x11..0x55) on consecutive cycles with `status_in` = 0 -> `byte_ready` = 0 after the 4th push, 0x55 is dropped, `fifo_count` = 4. Then set `status_in` to 1 -> 0x11, 0x22, 0x33, 0x44 are sent in order, `bytes_sent` = 4.
REQ-033 Push 0xA5 and 0x3C back to back with `status_in` = 1 -> 8 strobes, exactly 2 low cycles, then 8 strobes. `bytes_sent` = 2.
REQ-034 Assert `reset` for 1 cycle after 4 bits of 0xFF with 2 bytes queued -> `write_out` = 0 immediately, `fifo_count` = 0, `bytes_sent` = 0, `byte_ready` = 1. No further strobes occur.
REQ-035 Drop `status_in` to 0 after bit 3 of 0xC3 -> all 8 bits 1,1,0,0,0,0,1,1 are still sent. The next queued byte waits for `status_in` = 1.

Source files
------------

// File: rtl/serializer.sv
// Byte serializer: 4-deep input FIFO feeding an MSB-first bit shifter.
// Each byte is framed by 8 write_out strobes followed by at least 2 idle cycles.
module serializer (
   input  logic       clk_100khz,
   input  logic       reset,
   input  logic [7:0] data_in,
   input  logic       data_valid,
   output logic       byte_ready,
   output logic       data_out,
   output logic       write_out,
   input  logic       status_in,
   output logic       tx_busy,
   output logic [2:0] fifo_count,
   output logic [7:0] bytes_sent
);

   typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

   state_t     state;
   logic [7:0] mem [4];
   logic [1:0] wr_ptr;
   logic [1:0] rd_ptr;
   logic [2:0] count;
   logic [6:0] shreg;
   logic [2:0] bit_cnt;
   logic       push;
   logic       pop;
   logic [7:0] head;

   assign byte_ready = (count != 3'd4);
   assign fifo_count = count;
   assign tx_busy    = (state != IDLE);
   assign head       = mem[rd_ptr];
   assign push       = data_valid & byte_ready;
   // pop sees only the start-of-cycle count, so a same-edge push is not visible
   assign pop        = (state == IDLE) && (count != 3'd0) && status_in;

   always_ff @(posedge clk_100khz or posedge reset) begin
      if (reset) begin
         wr_ptr <= 2'd0;
         rd_ptr <= 2'd0;
         count  <= 3'd0;
         for (int i = 0; i < 4; i++) mem[i] <= 8'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= data_in;
            wr_ptr      <= wr_ptr + 2'd1;
         end
         if (pop) rd_ptr <= rd_ptr + 2'd1;
         count <= count + 3'(push) - 3'(pop);
      end
   end

   always_ff @(posedge clk_100khz or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         shreg      <= 7'd0;
         bit_cnt    <= 3'd0;
         data_out   <= 1'b0;
         write_out  <= 1'b0;
         bytes_sent <= 8'd0;
      end else begin
         unique case (state)
            IDLE: begin
               if (pop) begin
                  shreg     <= head[6:0];
                  data_out  <= head[7];
                  write_out <= 1'b1;
                  bit_cnt   <= 3'd0;
                  state     <= SHIFT;
               end else begin
                  data_out  <= 1'b0;
                  write_out <= 1'b0;
               end
            end
            SHIFT: begin
               if (bit_cnt != 3'd7) begin
                  bit_cnt  <= bit_cnt + 3'd1;
                  data_out <= shreg[6];
                  shreg    <= {shreg[5:0], 1'b0};
               end else begin
                  data_out   <= 1'b0;
                  write_out  <= 1'b0;
                  bytes_sent <= bytes_sent + 8'd1;
                  state      <= GAP;
               end
            end
            default: begin
               data_out  <= 1'b0;
               write_out <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule
